// File: rtl/seg7_pkg.sv
// Shared definitions for the 8-digit common-anode 7-segment scan controller.
// Holds the inactive pin levels, the digit count, the slot-phase state type,
// the captured-frame record and the hex-to-segment lookup table
// (bit order gfedcba, active-high, i.e. before inversion for the pins).
package seg7_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Entry n is the active-high gfedcba pattern for hex digit n; the table is
  // written from F down to 0 so that HEX_SEG_TABLE[n] selects digit n.
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Each digit slot opens with a blanking guard, then shows the digit.
  typedef enum logic {
    SLOT_BLANK,
    SLOT_SHOW
  } slot_state_t;

  // One complete display image: hex value, decimal points and digit enables.
  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  en;
  } disp_frame_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// Purely combinational hex nibble to 7-segment decoder.
// Ports:
//   nibble  in  4  hex digit 0..F
//   seg     out 7  segment pattern {g,f,e,d,c,b,a}, active-high
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // A straight table lookup keeps the glyph definitions in one place (the
  // package), so the decoder and any future users can never disagree.
  assign seg = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit common-anode 7-segment
// display. Each digit owns a slot of REFRESH_DIV clocks; the first
// BLANK_CYCLES of every slot keep all anodes off to suppress ghosting.
// New display contents are staged in a shadow register and only become
// visible at the end of digit 7's slot, so a frame never tears.
// Ports:
//   clk         in  1   system clock
//   rst         in  1   asynchronous reset, active-high
//   data        in  32  hex value, data[4k+3:4k] drives digit k (digit 0 = AN[0])
//   dp_in       in  8   decimal point request per digit, active-high
//   digit_en    in  8   digit enable per digit, active-high
//   load        in  1   strobe capturing data/dp_in/digit_en
//   CA..CG      out 1   segments a..g, active-low
//   DP          out 1   decimal point, active-low
//   AN          out 8   digit selects, active-low
//   frame_done  out 1   one-cycle pulse for the last cycle of digit 7's slot
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  digit_en,
  input  logic        load,
  output logic        CA,
  output logic        CB,
  output logic        CC,
  output logic        CD,
  output logic        CE,
  output logic        CF,
  output logic        CG,
  output logic        DP,
  output logic [7:0]  AN,
  output logic        frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX    = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK  = CW'(BLANK_CYCLES);
  localparam logic [2:0]    LAST_DIGIT = 3'(NUM_DIGITS - 1);
  localparam slot_state_t   STATE_RST  = (BLANK_CYCLES > 0) ? SLOT_BLANK : SLOT_SHOW;

  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    idx, idx_next;
  slot_state_t   state, state_next;

  disp_frame_t   shadow, active, load_frame;
  logic          pending;

  logic [7:0]    an_q, an_next;
  logic [6:0]    seg_q, seg_next;
  logic          dp_q, dp_next;
  logic          fd_q, fd_next;

  logic          cnt_wrap;
  logic          boundary;
  logic [3:0]    cur_nibble;
  logic [6:0]    cur_glyph;

  assign load_frame = {data, dp_in, digit_en};
  assign cnt_wrap   = (cnt == CNT_MAX);
  assign boundary   = cnt_wrap && (idx == LAST_DIGIT);
  assign cur_nibble = active.data[{idx, 2'b00} +: 4];

  seg7_hex_decode u_decode (
    .nibble (cur_nibble),
    .seg    (cur_glyph)
  );

  // Scan position and slot phase. The phase register is loaded with the
  // phase belonging to the next counter value, so it always agrees with cnt.
  // Reset drops the scanner back to digit 0, cycle 0 of the blanking guard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      idx   <= '0;
      state <= STATE_RST;
    end else begin
      cnt   <= cnt_next;
      idx   <= idx_next;
      state <= state_next;
    end
  end

  // Next scan position, next phase, and the pin values for the current
  // position. Pins are computed from the present state and registered, which
  // gives every output exactly one cycle of latency. Segment and DP drive
  // follow the digit even when its anode is disabled; the anode alone decides
  // whether anything lights, and a disabled digit still burns its whole slot
  // so the enabled ones keep a uniform duty cycle.
  always_comb begin
    cnt_next   = cnt_wrap ? '0 : cnt + CW'(1);
    idx_next   = cnt_wrap ? idx + 3'd1 : idx;
    state_next = (cnt_next < CNT_BLANK) ? SLOT_BLANK : SLOT_SHOW;
    an_next    = AN_OFF;
    seg_next   = SEG_OFF;
    dp_next    = 1'b1;
    fd_next    = boundary;
    case (state)
      SLOT_BLANK: begin
      end
      SLOT_SHOW: begin
        if (active.en[idx]) begin
          an_next = ~(8'b1 << idx);
        end
        seg_next = ~cur_glyph;
        dp_next  = ~active.dp[idx];
      end
      default: begin
      end
    endcase
  end

  // Tear-free update path. Every load lands in the shadow register; the
  // displayed image only changes at the frame boundary. A load coinciding
  // with the boundary bypasses the shadow wait and goes live immediately,
  // leaving nothing pending, so it costs no extra frame of delay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      if (load) begin
        shadow <= load_frame;
      end
      if (boundary) begin
        if (load) begin
          active <= load_frame;
        end else if (pending) begin
          active <= shadow;
        end
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // Pin registers. The asynchronous reset blanks the display the moment rst
  // rises rather than waiting for the next clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q  <= AN_OFF;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
      fd_q  <= 1'b0;
    end else begin
      an_q  <= an_next;
      seg_q <= seg_next;
      dp_q  <= dp_next;
      fd_q  <= fd_next;
    end
  end

  assign {CG, CF, CE, CD, CC, CB, CA} = seg_q;
  assign DP         = dp_q;
  assign AN         = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed testbench for seg7_scan_ctrl with an 8-cycle slot and a
// 2-cycle blanking guard (64-cycle frame). Expected pin values are
// hand-derived from the scan position: after the DUT has seen `cyc` clock
// edges since reset release, its pins show scan position cyc-1, where
// position p is digit (p/8)%8, slot cycle p%8.
module tb_seg7_scan_ctrl;

  localparam int RD = 8;
  localparam int BC = 2;

  // Active-high gfedcba glyphs for 0..F.
  localparam logic [6:0] HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data = '0;
  logic [7:0]  dp_in = '0;
  logic [7:0]  digit_en = '0;
  logic        load = 1'b0;
  logic        CA, CB, CC, CD, CE, CF, CG, DP, frame_done;
  logic [7:0]  AN;
  logic [6:0]  seg;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int multiLow = 0;
  int fdCount = 0;
  int fdPos [8] = '{-1, -1, -1, -1, -1, -1, -1, -1};
  bit recordFd = 1'b0;

  assign seg = {CG, CF, CE, CD, CC, CB, CA};

  seg7_scan_ctrl #(
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .load       (load),
    .CA         (CA),
    .CB         (CB),
    .CC         (CC),
    .CD         (CD),
    .CE         (CE),
    .CF         (CF),
    .CG         (CG),
    .DP         (DP),
    .AN         (AN),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Watch every cycle for more than one lit digit, and log where frame_done
  // pulses while the frame-timing window is open.
  always @(negedge clk) begin
    if (!rst) begin
      if ($countones(~AN) > 1) multiLow++;
      if (recordFd && frame_done) begin
        if (fdCount < 8) fdPos[fdCount] = cyc - 1;
        fdCount++;
      end
    end
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic runTo(input int target);
    while (cyc < target) stepCycle();
  endtask

  task automatic applyStimulus(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] en);
    data     = d;
    dp_in    = dp;
    digit_en = en;
    load     = 1'b1;
    stepCycle();
    load     = 1'b0;
  endtask

  task automatic checkPins(input string tag, input int p, input logic [7:0] expAn,
                           input logic [6:0] expSeg, input logic expDp);
    runTo(p + 1);
    checkOutput({tag, ".an"},  int'(AN),  int'(expAn));
    checkOutput({tag, ".seg"}, int'(seg), int'(expSeg));
    checkOutput({tag, ".dp"},  int'(DP),  int'(expDp));
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst.an",  int'(AN),  'hFF);
    checkOutput("rst.seg", int'(seg), 'h7F);
    checkOutput("rst.dp",  int'(DP),  1);
    checkOutput("rst.fd",  int'(frame_done), 0);
    rst = 1'b0;
    cyc = 0;

    // Test 1: load counting pattern at position 0, visible from frame 1
    applyStimulus(32'h76543210, 8'h00, 8'hFF);
    checkPins("f0.s0show", 2, 8'hFF, 7'h40, 1'b1);
    checkPins("f0.s1show", 10, 8'hFF, 7'h40, 1'b1);
    for (int k = 0; k < 8; k++) begin
      checkPins($sformatf("t1.d%0d.blank", k), 64 + 8*k + 1, 8'hFF, 7'h7F, 1'b1);
      checkPins($sformatf("t1.d%0d.show", k),  64 + 8*k + 2, ~(8'h01 << k), ~HEX[k], 1'b1);
      checkPins($sformatf("t1.d%0d.end", k),   64 + 8*k + 7, ~(8'h01 << k), ~HEX[k], 1'b1);
    end

    // Test 2: only digits 0 and 2 enabled, decimal point on digit 2
    runTo(130);
    applyStimulus(32'h76543210, 8'h04, 8'h05);
    checkPins("t2.d0",       194, 8'hFE, 7'h40, 1'b1);
    checkPins("t2.d1",       202, 8'hFF, 7'h79, 1'b1);
    checkPins("t2.d2.blank", 208, 8'hFF, 7'h7F, 1'b1);
    checkPins("t2.d2.show",  212, 8'hFB, 7'h24, 1'b0);
    checkPins("t2.d3",       221, 8'hFF, 7'h30, 1'b1);
    checkPins("t2.d7",       255, 8'hFF, 7'h78, 1'b1);

    // Test 3: two loads mid-frame, last one wins at the next frame
    runTo(283);
    applyStimulus(32'hFFFFFFFF, 8'h00, 8'hFF);
    checkPins("t3.old.d5", 299, 8'hFF, 7'h12, 1'b1);
    applyStimulus(32'h0000000A, 8'h00, 8'hFF);
    checkPins("t3.old.d7", 316, 8'hFF, 7'h78, 1'b1);
    checkPins("t3.new.d0", 322, 8'hFE, 7'h08, 1'b1);
    checkPins("t3.new.d1", 330, 8'hFD, 7'h40, 1'b1);
    checkPins("t3.new.d7", 378, 8'h7F, 7'h40, 1'b1);

    // Test 4: load exactly on the boundary goes live in the next frame
    runTo(383);
    applyStimulus(32'h00000001, 8'h00, 8'hFF);
    checkPins("t4.d0.blank", 384, 8'hFF, 7'h7F, 1'b1);
    checkPins("t4.d0.show",  386, 8'hFE, 7'h79, 1'b1);
    checkPins("t4.d1.show",  394, 8'hFD, 7'h40, 1'b1);
    checkPins("t4.next.d0",  450, 8'hFE, 7'h79, 1'b1);

    // Test 5: asynchronous reset in the middle of digit 5's SHOW phase
    checkPins("t5.pre", 492, 8'hDF, 7'h40, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("t5.async.an",  int'(AN),  'hFF);
    checkOutput("t5.async.seg", int'(seg), 'h7F);
    checkOutput("t5.async.dp",  int'(DP),  1);
    checkOutput("t5.async.fd",  int'(frame_done), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    recordFd = 1'b1;
    checkPins("t5.post.blank", 0, 8'hFF, 7'h7F, 1'b1);
    checkPins("t5.post.show",  2, 8'hFF, 7'h40, 1'b1);
    checkPins("t5.post.d1",   10, 8'hFF, 7'h40, 1'b1);

    // Test 6: three frames of frame_done timing
    runTo(193);
    recordFd = 1'b0;
    checkOutput("t6.fd.count", fdCount, 3);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("t6.fd.pos%0d", i), fdPos[i], 63 + 64*i);
    end
    checkOutput("an.onehot", multiLow, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for the 8-digit, common-anode 7-segment display on the board. Segment lines and digit selects are active-low.
- Takes a 32-bit hex value (8 nibbles), a per-digit decimal-point mask and a per-digit enable mask.
- Sequences one digit at a time, with a blanking guard between digits to suppress ghosting.
- Sits between user logic and the CA..CG/DP/AN pins; replaces static, switch-driven segment control.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz slot rate at 100 MHz, 125 Hz frame rate); must be >= 2.
- BLANK_CYCLES, 16, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous reset, active-high
- data  in  32  hex value; data[4k+3:4k] drives digit k (digit 0 = rightmost, AN[0])
- dp_in  in  8  decimal-point request per digit, active-high
- digit_en  in  8  digit enable per digit, active-high
- load  in  1  single-cycle strobe; captures data/dp_in/digit_en into the shadow register
- CA,CB,CC,CD,CE,CF,CG  out  1 each  segment a..g, active-low
- DP  out  1  decimal point, active-low
- AN  out  8  digit selects, active-low
- frame_done  out  1  one-cycle pulse at the end of digit 7's slot

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst is asynchronous and active-high.
  - While rst is high: AN=8'hFF, CA..CG=1, DP=1, frame_done=0, digit index=0, slot counter=0, shadow and active registers=0, pending flag=0.
  - Reset mid-slot aborts immediately. After release, scanning restarts at digit 0, cycle 0 of the BLANK phase.
- Slot counter:
  - cnt counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, digit index increments 0..7 and wraps 7->0.
- State machine, two states per slot:
  - BLANK: cnt < BLANK_CYCLES. AN=8'hFF; segments held at 1.
  - SHOW: cnt >= BLANK_CYCLES. AN = ~(8'b1 << idx) if active_en[idx]=1, else 8'hFF.
  - In SHOW, segments = ~decode(active_data nibble idx) and DP = ~active_dp[idx].
  - A disabled digit still consumes its full slot, so enabled digits keep uniform brightness.
- Hex decode (gfedcba, active-high before inversion):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Output registers:
  - All pin outputs are registered.
  - Pins reflect the state/counter of the previous cycle: fixed 1-cycle latency.
- Frame-synchronous update (tear-free):
  - load copies data/dp_in/digit_en into the shadow register and sets pending.
  - At the frame boundary (cnt wraps from REFRESH_DIV-1 with idx=7), if pending: shadow -> active, pending cleared.
  - A second load before the boundary overwrites the shadow; last value wins.
  - load in the same cycle as the boundary: the new inputs go directly to active, pending is left clear.
- frame_done:
  - Asserted on the pin cycle corresponding to the boundary cycle (cnt=REFRESH_DIV-1, idx=7), one cycle wide.
  - Period = 8*REFRESH_DIV cycles.
- Width rule: cnt is $clog2(REFRESH_DIV) bits; idx is 3 bits.

Decomposition:
- Shared package seg7_pkg:
  - SEG_OFF = 7'h7F
  - AN_OFF = 8'hFF
  - 16-entry hex-to-segment constant table
  - NUM_DIGITS = 8
- One natural sub-module: seg7_hex_decode, a purely combinational 4-bit -> 7-bit active-high decoder.
- Counter, FSM, shadow/active registers and output registers stay in seg7_scan_ctrl.

Test Plan (REFRESH_DIV=8, BLANK_CYCLES=2):
1. Reset, then load data=32'h76543210, digit_en=FF, dp_in=00.
   -> After the first frame boundary, each slot shows AN=FF for 2 cycles, then AN=~(1<<k) for 6 cycles.
   -> Segments {CG..CA} = ~decode(k): e.g. digit 0 -> 7'h40, digit 1 -> 7'h79.
2. digit_en=8'b0000_0101, dp_in=8'h04.
   -> AN pulses low only in slots 0 and 2; slots 1 and 3..7 keep AN=FF for all 8 cycles.
   -> DP=0 only during SHOW of slot 2.
3. Load 32'hFFFFFFFF mid-frame at digit 3, then 32'h0000000A before the boundary.
   -> The remainder of the frame still shows the old value; the next frame shows A on digit 0 (7'h08) and 0 on the others.
4. Assert load exactly on the boundary cycle with data=32'h00000001.
   -> The first SHOW of digit 0 in the new frame shows 7'h79.
   -> No additional frame of delay; pending stays 0.
5. Assert rst mid-SHOW of digit 5.
   -> AN=FF, segments=1, DP=1 within the same cycle (asynchronous).
   -> After release, BLANK phase of digit 0 begins; active value reads 0 (AN stays FF because digit_en=0).
6. Run 3 frames.
   -> frame_done pulses exactly 3 times, 64 cycles apart, each 1 cycle wide.
   -> No cycle ever has more than one AN bit low.
